// File: rtl/instr_queue_mt.sv
// instr_queue_mt: multi-threaded instruction queue.
// Each of NTHREADS threads owns a private circular buffer of DEPTH entries.
// Up to WR_PORTS entries are written and up to RD_PORTS entries are read per cycle.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_wen/wr_thread   write request and target thread
//   wr_en/wr_data      per-slot enables (leading ones count) and packed payload
//   wr_stall           combinational: fewer than WR_PORTS free entries in wr_thread
//   rd_clkEn/rd_thread read request and source thread
//   rd_en              per-slot read enables (leading ones count)
//   rd_avail/rd_count  combinational occupancy view of rd_thread
//   rd_data/rd_valid   registered read results, one cycle after the request
//   flush/flush_thread discard all contents of one thread
module instr_queue_mt #(
  parameter int WIDTH    = 80,
  parameter int DEPTH    = 48,
  parameter int NTHREADS = 2,
  parameter int WR_PORTS = 16,
  parameter int RD_PORTS = 11,
  localparam int TW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_wen,
  input  logic [TW-1:0]                wr_thread,
  input  logic [WR_PORTS-1:0]          wr_en,
  input  logic [WR_PORTS*WIDTH-1:0]    wr_data,
  output logic                         wr_stall,
  input  logic                         rd_clkEn,
  input  logic [TW-1:0]                rd_thread,
  input  logic [RD_PORTS-1:0]          rd_en,
  output logic [RD_PORTS-1:0]          rd_avail,
  output logic [RD_PORTS*WIDTH-1:0]    rd_data,
  output logic [RD_PORTS-1:0]          rd_valid,
  output logic [CW-1:0]                rd_count,
  input  logic                         flush,
  input  logic [TW-1:0]                flush_thread
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    wptr_r [NTHREADS];
  logic [PW-1:0]    rptr_r [NTHREADS];
  logic [CW-1:0]    cnt_r  [NTHREADS];
  logic [WIDTH-1:0] mem_r  [NTHREADS][DEPTH];

  logic             wr_tok_s, rd_tok_s;
  logic [CW-1:0]    wr_cnt_s, rd_cnt_s;
  logic [PW-1:0]    wr_wptr_s, rd_rptr_s;
  logic [CW-1:0]    wr_nw_s, rd_nr_s, rd_g_s;
  logic             wr_acc_s, rd_go_s;
  logic [RD_PORTS-1:0] rd_vmask_s;

  // (base + off) mod DEPTH; base < DEPTH and off <= DEPTH, so one subtract suffices
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [CW-1:0] off);
    logic [CW:0] sum;
    sum = (CW+1)'(base) + (CW+1)'(off);
    if (sum >= (CW+1)'(DEPTH)) begin
      sum = sum - (CW+1)'(DEPTH);
    end else begin
      sum = sum;
    end
    return sum[PW-1:0];
  endfunction

  // Thread selection, leading-ones counts, grant and accept decisions
  always_comb begin
    logic run;
    wr_tok_s  = (int'(wr_thread) < NTHREADS);
    rd_tok_s  = (int'(rd_thread) < NTHREADS);
    wr_cnt_s  = wr_tok_s ? cnt_r[wr_thread]  : '0;
    wr_wptr_s = wr_tok_s ? wptr_r[wr_thread] : '0;
    rd_cnt_s  = rd_tok_s ? cnt_r[rd_thread]  : '0;
    rd_rptr_s = rd_tok_s ? rptr_r[rd_thread] : '0;

    // Only the contiguous run of ones starting at slot 0 counts
    wr_nw_s = '0;
    run = 1'b1;
    for (int i = 0; i < WR_PORTS; i++) begin
      if (run && wr_en[i]) begin
        wr_nw_s = wr_nw_s + CW'(1);
      end else begin
        run = 1'b0;
      end
    end
    rd_nr_s = '0;
    run = 1'b1;
    for (int i = 0; i < RD_PORTS; i++) begin
      if (run && rd_en[i]) begin
        rd_nr_s = rd_nr_s + CW'(1);
      end else begin
        run = 1'b0;
      end
    end

    rd_g_s   = (rd_nr_s < rd_cnt_s) ? rd_nr_s : rd_cnt_s;
    wr_stall = ((DEPTH - int'(wr_cnt_s)) < WR_PORTS);
    wr_acc_s = wr_wen && wr_tok_s && !wr_stall && !(flush && (flush_thread == wr_thread));
    rd_go_s  = rd_clkEn && rd_tok_s && !(flush && (flush_thread == rd_thread));

    rd_count = rd_cnt_s;
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_avail[i]   = (int'(rd_cnt_s) > i);
      rd_vmask_s[i] = rd_go_s && (i < int'(rd_g_s));
    end
  end

  // Per-thread pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    for (int t = 0; t < NTHREADS; t++) begin
      if (rst || (flush && (int'(flush_thread) == t))) begin
        wptr_r[t] <= '0;
        rptr_r[t] <= '0;
        cnt_r[t]  <= '0;
      end else begin
        if (wr_acc_s && (int'(wr_thread) == t)) begin
          wptr_r[t] <= wrap_add(wptr_r[t], wr_nw_s);
        end
        if (rd_go_s && (int'(rd_thread) == t)) begin
          rptr_r[t] <= wrap_add(rptr_r[t], rd_g_s);
        end
        // Accepted writes never overflow: acceptance needs WR_PORTS free entries
        cnt_r[t] <= cnt_r[t]
                  + ((wr_acc_s && (int'(wr_thread) == t)) ? wr_nw_s : '0)
                  - ((rd_go_s  && (int'(rd_thread) == t)) ? rd_g_s  : '0);
      end
    end
  end

  // Payload storage; not reset, contents only escape through qualified reads
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_s) begin
      for (int i = 0; i < WR_PORTS; i++) begin
        if (i < int'(wr_nw_s)) begin
          mem_r[wr_thread][wrap_add(wr_wptr_s, CW'(i))] <= wr_data[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Registered read port: data loads on every valid-thread request, valid only for granted slots
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_vmask_s;
      if (rd_clkEn && rd_tok_s) begin
        for (int i = 0; i < RD_PORTS; i++) begin
          rd_data[i*WIDTH +: WIDTH] <= mem_r[rd_thread][wrap_add(rd_rptr_s, CW'(i))];
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_queue_mt.sv
// Scoreboard bench for instr_queue_mt with default parameters.
module tb_instr_queue_mt;
  localparam int W = 80, D = 48, NT = 2, WP = 16, RP = 11, CW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, wr_wen, rd_clkEn, flush;
  logic [0:0] wr_thread, rd_thread, flush_thread;
  logic [WP-1:0] wr_en;
  logic [WP*W-1:0] wr_data;
  logic wr_stall;
  logic [RP-1:0] rd_en, rd_avail, rd_valid;
  logic [RP*W-1:0] rd_data;
  logic [CW-1:0] rd_count;

  instr_queue_mt dut (
    .clk(clk), .rst(rst), .wr_wen(wr_wen), .wr_thread(wr_thread), .wr_en(wr_en),
    .wr_data(wr_data), .wr_stall(wr_stall), .rd_clkEn(rd_clkEn), .rd_thread(rd_thread),
    .rd_en(rd_en), .rd_avail(rd_avail), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_count(rd_count), .flush(flush), .flush_thread(flush_thread)
  );

  typedef struct packed {
    logic [RP-1:0]   v;
    logic [RP*W-1:0] d;
  } exp_t;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] mq [NT][$];
  exp_t sb[$];
  exp_t mon_e;
  logic [W-1:0] next_val;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation whenever the DUT presents valid read data
  always @(negedge clk) begin
    if (!rst && (rd_valid !== '0)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: rd_valid=%0h expected none", rd_valid);
      end else begin
        mon_e = sb.pop_front();
        tests++;
        if (rd_valid !== mon_e.v) begin
          fails++;
          $display("FAIL rd_valid: got %0h expected %0h", rd_valid, mon_e.v);
        end
        for (int i = 0; i < RP; i++) begin
          if (mon_e.v[i]) begin
            tests++;
            if (rd_data[i*W +: W] !== mon_e.d[i*W +: W]) begin
              fails++;
              $display("FAIL rd_data[%0d]: got %0h expected %0h", i,
                       rd_data[i*W +: W], mon_e.d[i*W +: W]);
            end
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    wr_wen = 1'b0; wr_en = '0; rd_clkEn = 1'b0; rd_en = '0; flush = 1'b0;
  endtask

  // One cycle of stimulus; the model predicts stall/occupancy and queues expected reads
  task automatic step(input bit wwen, input bit wthr, input logic [WP-1:0] wen,
                      input bit rce, input bit rthr, input logic [RP-1:0] ren,
                      input bit fl, input bit fthr);
    int nw, nr, g;
    bit stall_e;
    logic [RP-1:0] av_e;
    exp_t e;
    wr_wen = wwen; wr_thread = wthr; wr_en = wen;
    for (int i = 0; i < WP; i++) wr_data[i*W +: W] = next_val + W'(i);
    rd_clkEn = rce; rd_thread = rthr; rd_en = ren;
    flush = fl; flush_thread = fthr;
    #1;
    stall_e = (D - mq[wthr].size()) < WP;
    chk("wr_stall", 64'(wr_stall), 64'(stall_e));
    chk("rd_count", 64'(rd_count), 64'(mq[rthr].size()));
    av_e = '0;
    for (int i = 0; i < RP; i++) if (mq[rthr].size() > i) av_e[i] = 1'b1;
    chk("rd_avail", 64'(rd_avail), 64'(av_e));
    nw = 0;
    for (int i = 0; i < WP; i++) if (wen[i] && nw == i) nw++;
    nr = 0;
    for (int i = 0; i < RP; i++) if (ren[i] && nr == i) nr++;
    if (rce && !(fl && fthr == rthr)) begin
      g = (nr < mq[rthr].size()) ? nr : mq[rthr].size();
      e = '0;
      for (int i = 0; i < g; i++) begin
        e.v[i] = 1'b1;
        e.d[i*W +: W] = mq[rthr].pop_front();
      end
      if (g > 0) sb.push_back(e);
    end
    if (wwen && !stall_e && !(fl && fthr == wthr)) begin
      for (int i = 0; i < nw; i++) mq[wthr].push_back(next_val + W'(i));
      next_val = next_val + W'(nw);
    end
    if (fl) mq[fthr].delete();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Hand-computed occupancy and stall for one thread
  task automatic hand(input string name, input bit thr, input int exp_cnt, input bit exp_stall);
    rd_thread = thr; wr_thread = thr;
    #1;
    chk({name, "_cnt"}, 64'(rd_count), 64'(exp_cnt));
    chk({name, "_stall"}, 64'(wr_stall), 64'(exp_stall));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_thread = '0; rd_thread = '0; flush_thread = '0; wr_data = '0;
    idle_inputs();
    next_val = W'(1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_data_zero", 64'(rd_data == '0), 64'(1));
    chk("rst_rd_avail", 64'(rd_avail), 64'(0));
    hand("rst", 1'b0, 0, 1'b0);

    // Basic write 8, read 5
    step(1, 0, 16'h00FF, 0, 0, 11'h000, 0, 0);
    hand("r36_w8", 1'b0, 8, 1'b0);
    step(0, 0, 16'h0000, 1, 0, 11'h01F, 0, 0);
    hand("r36_r5", 1'b0, 3, 1'b0);
    step(0, 0, 16'h0000, 1, 0, 11'h7FF, 0, 0);
    hand("r36_drain", 1'b0, 0, 1'b0);

    // Stall threshold at 33 entries
    step(1, 0, 16'hFFFF, 0, 0, 11'h000, 0, 0);
    step(1, 0, 16'hFFFF, 0, 0, 11'h000, 0, 0);
    step(1, 0, 16'h0001, 0, 0, 11'h000, 0, 0);
    hand("r37_33", 1'b0, 33, 1'b1);
    step(1, 0, 16'hFFFF, 0, 0, 11'h000, 0, 0);
    hand("r37_drop", 1'b0, 33, 1'b1);
    step(0, 0, 16'h0000, 1, 0, 11'h001, 0, 0);
    hand("r37_rd1", 1'b0, 32, 1'b0);
    step(1, 0, 16'hFFFF, 0, 0, 11'h000, 0, 0);
    hand("r37_full", 1'b0, 48, 1'b1);
    repeat (5) step(0, 0, 16'h0000, 1, 0, 11'h7FF, 0, 0);
    hand("r37_drain", 1'b0, 0, 1'b0);

    // Wrap-around: flush to zero the pointers, cycle 46 entries, then 6 more
    step(0, 0, 16'h0000, 0, 0, 11'h000, 1, 0);
    step(1, 0, 16'hFFFF, 0, 0, 11'h000, 0, 0);
    step(1, 0, 16'hFFFF, 1, 0, 11'h7FF, 0, 0);
    step(1, 0, 16'h3FFF, 1, 0, 11'h7FF, 0, 0);
    hand("r38_mid", 1'b0, 24, 1'b0);
    repeat (3) step(0, 0, 16'h0000, 1, 0, 11'h7FF, 0, 0);
    hand("r38_46", 1'b0, 0, 1'b0);
    step(1, 0, 16'h003F, 0, 0, 11'h000, 0, 0);
    step(0, 0, 16'h0000, 1, 0, 11'h03F, 0, 0);
    hand("r38_wrap", 1'b0, 0, 1'b0);

    // Partial grant on thread 1, thread 0 untouched
    step(1, 0, 16'h0003, 0, 0, 11'h000, 0, 0);
    step(1, 1, 16'h001F, 0, 0, 11'h000, 0, 0);
    rd_thread = 1'b1;
    #1;
    chk("r39_avail", 64'(rd_avail), 64'(11'h01F));
    step(0, 0, 16'h0000, 1, 1, 11'h7FF, 0, 0);
    hand("r39_t1", 1'b1, 0, 1'b0);
    hand("r39_t0", 1'b0, 2, 1'b0);

    // Flush thread 1 with concurrent write to it and read of thread 0
    step(1, 1, 16'h0007, 0, 0, 11'h000, 0, 0);
    step(1, 1, 16'h000F, 1, 0, 11'h003, 1, 1);
    hand("r40_t1", 1'b1, 0, 1'b0);
    hand("r40_t0", 1'b0, 0, 1'b0);
    step(1, 1, 16'h0007, 0, 0, 11'h000, 0, 0);
    step(0, 0, 16'h0000, 1, 1, 11'h7FF, 1, 1);
    hand("flush_rd_t1", 1'b1, 0, 1'b0);

    // Non-contiguous enables write only one entry
    step(1, 0, 16'h000D, 0, 0, 11'h000, 0, 0);
    hand("r41", 1'b0, 1, 1'b0);
    step(0, 0, 16'h0000, 1, 0, 11'h7FF, 0, 0);
    step(0, 0, 16'h0000, 1, 0, 11'h7FF, 0, 0);
    hand("empty_rd", 1'b0, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
